alarme_saida_driver: RTL and testbench
======================================

Name: alarme_saida_driver

Overview:
- Output stage directly downstream of the alarm control FSM. It consumes the FSM's 3-bit output-level code and turns it into physical drive patterns.
- The drive patterns are: a blinking LED, a pulsed vibrator and a gated square-wave buzzer tone.
- All pattern timing is done with clock-cycle counters, so the control FSM stays free of delays.

Parameters:
- BLINK_HALF, 12500000, LED on-time and off-time in clk cycles (min 1)
- VIB_ON, 10000000, vibrator on-time in clk cycles (min 1)
- VIB_OFF, 15000000, vibrator off-time in clk cycles (min 1)
- TONE_HALF, 12500, buzzer half-period in clk cycles (min 1; 2 kHz at 50 MHz)
- CNT_W, 24, width of every timing counter; each parameter must be <= 2^CNT_W

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- saida_in  in  3  level code from control FSM: bit0 LED, bit1 vibrator, bit2 buzzer
- led  out  1  LED drive
- vibra  out  1  vibrator drive
- buzzer  out  1  speaker drive
- ativo  out  1  high while a valid non-zero code is held
- err  out  1  sticky invalid-code flag

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset: code_r=000; all counters 0; vibrator FSM in V_IDLE; led=vibra=buzzer=ativo=err=0 after the first edge with rst=1.
  - rst overrides every other input.
  - Asserting rst mid-pattern clears everything on that edge, with no pattern completion.
- Input stage: saida_in is registered into code_r on every edge.
  - Valid codes: 000, 001, 011, 111.
  - Any other code is treated as 000 (all enables 0) and sets err=1.
  - err stays 1 until rst.
- Latency: a code presented before edge k reaches code_r at edge k; outputs respond at edge k+1 (2 edges total).
- Enables: en_led=code_r[0], en_vib=code_r[1], en_tone=code_r[2], all taken from valid codes only.
- ativo <= (code_r valid and != 000).
- LED blinker:
  - en_led=0: led<=0, led_cnt<=0.
  - en_led rising (registered enable was 0): led<=1, led_cnt<=0.
  - Otherwise led_cnt increments. When led_cnt==BLINK_HALF-1, led toggles and led_cnt<=0.
  - Result: exactly BLINK_HALF cycles high, then BLINK_HALF cycles low, repeating.
- Vibrator FSM, states V_IDLE, V_ON, V_OFF:
  - V_IDLE: en_vib=1 -> V_ON, vib_cnt<=0, vibra<=1.
  - V_ON: vib_cnt==VIB_ON-1 -> V_OFF, vib_cnt<=0, vibra<=0; else count.
  - V_OFF: vib_cnt==VIB_OFF-1 -> V_ON, vib_cnt<=0, vibra<=1; else count.
  - In any state, en_vib=0 -> V_IDLE, vibra<=0, vib_cnt<=0 on that edge.
- Tone generator:
  - en_tone=0: tone<=0, tone_cnt<=0.
  - en_tone rising: tone<=1, tone_cnt<=0.
  - Otherwise toggle tone when tone_cnt==TONE_HALF-1.
  - buzzer is the register-to-output AND of tone and led; no extra latency. The speaker therefore sounds only during the LED on-phase.
- Level changes:
  - 111->011: tone and buzzer clear on the next edge; LED and vibrator phases continue unperturbed.
  - 011->111: tone starts at 1 on the next edge.
  - Any code->000: all outputs 0 on the next edge.
  - A subsequent re-enable restarts each pattern from its on-phase.
- Parameter value 1: the corresponding signal toggles every cycle.
- Counters never exceed parameter-1, so no wrap-around occurs.

Test Plan:
- Simulation overrides for all scenarios: BLINK_HALF=4, VIB_ON=3, VIB_OFF=5, TONE_HALF=2, CNT_W=8.
- Reset: rst=1 for 3 cycles with saida_in=111 -> led, vibra, buzzer, ativo, err all 0 throughout; with rst low and 111 held, led=1 two edges after release.
- LED only: saida_in 000->001 before edge k -> led=1 and ativo=1 from edge k+1; led high 4 cycles, low 4, period 8; vibra=buzzer=0.
- LED+vibrator: saida_in=011 -> vibra high 3 cycles, low 5 (period 8) from edge k+1; led independently 4/4; buzzer=0.
- Full alarm then step-down: saida_in=111 -> buzzer toggles every 2 cycles only while led=1, 0 while led=0; switch to 011 -> buzzer=0 within 2 edges, led and vibra phases unchanged.
- Invalid code: saida_in=101 -> led, vibra, buzzer, ativo 0 within 2 edges; err=1. Then saida_in=001 -> led blinks again, err stays 1 until rst pulse.
- Reset mid-pattern: rst=1 for one cycle during 111 in led on-phase -> all outputs 0 on that edge. With rst low and 111 held: code_r reloads at the first edge after release, led=1 at the second edge.

Source files
------------

// File: rtl/alarme_saida_driver.sv
// Output stage for the alarm controller: turns the 3-bit level code into a
// blinking LED, a pulsed vibrator and a buzzer tone gated by the LED on-phase.
module alarme_saida_driver #(
  parameter int BLINK_HALF = 12500000,
  parameter int VIB_ON     = 10000000,
  parameter int VIB_OFF    = 15000000,
  parameter int TONE_HALF  = 12500,
  parameter int CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] saida_in,
  output logic       led,
  output logic       vibra,
  output logic       buzzer,
  output logic       ativo,
  output logic       err
);

  typedef enum logic [1:0] {V_IDLE, V_ON, V_OFF} vib_state_t;

  localparam logic [CNT_W-1:0] LED_LAST  = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] VON_LAST  = CNT_W'(VIB_ON - 1);
  localparam logic [CNT_W-1:0] VOFF_LAST = CNT_W'(VIB_OFF - 1);
  localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_HALF - 1);

  logic [2:0]       code_r;
  logic             code_valid;
  logic             en_led, en_vib, en_tone;
  logic             led_en_r, tone_en_r, tone;
  logic [CNT_W-1:0] led_cnt, tone_cnt, vib_cnt, vib_cnt_nxt;
  logic             vibra_nxt;
  vib_state_t       vib_state, vib_state_nxt;

  // Invalid codes behave as 000 so a glitchy upstream can never half-enable a pattern.
  assign code_valid = (code_r == 3'b000) || (code_r == 3'b001) ||
                      (code_r == 3'b011) || (code_r == 3'b111);
  assign en_led     = code_valid & code_r[0];
  assign en_vib     = code_valid & code_r[1];
  assign en_tone    = code_valid & code_r[2];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_r <= 3'b000;
      ativo  <= 1'b0;
      err    <= 1'b0;
    end else begin
      code_r <= saida_in;
      ativo  <= code_valid && (code_r != 3'b000);
      if (!code_valid) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en_led) begin
      led      <= 1'b0;
      led_en_r <= 1'b0;
      led_cnt  <= '0;
    end else if (!led_en_r) begin
      led      <= 1'b1;
      led_en_r <= 1'b1;
      led_cnt  <= '0;
    end else if (led_cnt == LED_LAST) begin
      led     <= ~led;
      led_cnt <= '0;
    end else begin
      led_cnt <= led_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en_tone) begin
      tone      <= 1'b0;
      tone_en_r <= 1'b0;
      tone_cnt  <= '0;
    end else if (!tone_en_r) begin
      tone      <= 1'b1;
      tone_en_r <= 1'b1;
      tone_cnt  <= '0;
    end else if (tone_cnt == TONE_LAST) begin
      tone     <= ~tone;
      tone_cnt <= '0;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

  assign buzzer = tone & led;

  always_ff @(posedge clk) begin
    if (rst) begin
      vib_state <= V_IDLE;
      vib_cnt   <= '0;
      vibra     <= 1'b0;
    end else begin
      vib_state <= vib_state_nxt;
      vib_cnt   <= vib_cnt_nxt;
      vibra     <= vibra_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    vib_state_nxt = vib_state;
    vib_cnt_nxt   = vib_cnt;
    vibra_nxt     = vibra;
    if (!en_vib) begin
      vib_state_nxt = V_IDLE;
      vib_cnt_nxt   = '0;
      vibra_nxt     = 1'b0;
    end else begin
      case (vib_state)
        V_IDLE: begin
          vib_state_nxt = V_ON;
          vib_cnt_nxt   = '0;
          vibra_nxt     = 1'b1;
        end
        V_ON: begin
          if (vib_cnt == VON_LAST) begin
            vib_state_nxt = V_OFF;
            vib_cnt_nxt   = '0;
            vibra_nxt     = 1'b0;
          end else begin
            vib_cnt_nxt = vib_cnt + 1'b1;
          end
        end
        V_OFF: begin
          if (vib_cnt == VOFF_LAST) begin
            vib_state_nxt = V_ON;
            vib_cnt_nxt   = '0;
            vibra_nxt     = 1'b1;
          end else begin
            vib_cnt_nxt = vib_cnt + 1'b1;
          end
        end
        default: begin
          vib_state_nxt = V_IDLE;
          vib_cnt_nxt   = '0;
          vibra_nxt     = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarme_saida_driver.sv
// Scoreboard bench: a cycle model built on "cycles since enable" arithmetic
// predicts each edge's outputs; a negedge monitor compares them to the DUT.
module tb_alarme_saida_driver;

  localparam int BH = 4, VON = 3, VOFF = 5, TH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] saida_in;
  logic       led, vibra, buzzer, ativo, err;

  typedef struct packed {
    logic led;
    logic vibra;
    logic buzzer;
    logic ativo;
    logic err;
  } out_t;

  out_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  alarme_saida_driver #(
    .BLINK_HALF(BH), .VIB_ON(VON), .VIB_OFF(VOFF), .TONE_HALF(TH), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .saida_in(saida_in),
    .led(led), .vibra(vibra), .buzzer(buzzer), .ativo(ativo), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act[4:0], exp[4:0]);
    end
  endtask

  // Reference model: each pattern is a function of how many cycles it has been enabled.
  logic [2:0] m_code = 3'b000;
  logic       m_err  = 1'b0;
  int age_led = -1, age_vib = -1, age_tone = -1;

  always @(posedge clk) begin
    out_t e;
    logic valid;
    logic [2:0] eff;
    e = '0;
    if (rst) begin
      m_code = 3'b000; m_err = 1'b0;
      age_led = -1; age_vib = -1; age_tone = -1;
    end else begin
      valid = (m_code == 3'b000) || (m_code == 3'b001) ||
              (m_code == 3'b011) || (m_code == 3'b111);
      eff   = valid ? m_code : 3'b000;
      if (!valid) m_err = 1'b1;
      age_led  = eff[0] ? age_led + 1  : -1;
      age_vib  = eff[1] ? age_vib + 1  : -1;
      age_tone = eff[2] ? age_tone + 1 : -1;
      e.led    = (age_led >= 0) && ((age_led / BH) % 2 == 0);
      e.vibra  = (age_vib >= 0) && ((age_vib % (VON + VOFF)) < VON);
      e.buzzer = e.led && (age_tone >= 0) && ((age_tone / TH) % 2 == 0);
      e.ativo  = (eff != 3'b000);
      e.err    = m_err;
      m_code   = saida_in;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    out_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("outputs{led,vibra,buzzer,ativo,err} cycle %0d", cyc),
            int'({led, vibra, buzzer, ativo, err}), int'(e));
    end
  end

  task automatic hold(input logic [2:0] code, input int n);
    saida_in = code;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [2:0] valid_codes [4];
    valid_codes = '{3'b000, 3'b001, 3'b011, 3'b111};
    rst = 1'b1;
    saida_in = 3'b111;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    hold(3'b111, 12);
    hold(3'b000, 3);
    hold(3'b001, 18);
    hold(3'b011, 20);
    hold(3'b111, 20);
    hold(3'b011, 10);
    hold(3'b101, 5);
    hold(3'b001, 18);
    pulse_rst();
    hold(3'b111, 3);
    pulse_rst();
    hold(3'b111, 12);
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 9) == 0) pulse_rst();
      if ($urandom_range(0, 9) < 8)
        hold(valid_codes[$urandom_range(0, 3)], $urandom_range(1, 20));
      else
        hold(3'($urandom_range(0, 7)), $urandom_range(1, 4));
    end
    hold(3'b000, 3);
    repeat (2) @(negedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 0);
    if (n_cmp < 12) begin
      n_bad++;
      $display("FAIL too few comparisons: got %0d expected at least 12", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
